// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if - decoder/sequencer bundle for the Mica program-counter
// sequencer.
//   en      : advance enable (0 = stall)
//   opc     : 4-bit sequencing opcode
//   x       : condition flag for conditional opcodes
//   dir     : absolute target or two's-complement relative offset (AW bits)
//   pc      : current program address (AW bits)
//   sp      : number of valid return-stack entries ($clog2(SD+1) bits)
//   halted  : sticky halt indication
//   stk_ovf : sticky CALL-with-full-stack flag
//   stk_unf : sticky RET-with-empty-stack flag
// The master modport is the decoder side; the slave modport is the sequencer.
// AW and SD must match the parameters of the attached pc_sequencer.
interface pc_sequencer_if #(
  parameter int AW = 4,
  parameter int SD = 4
);
  localparam int SPW = $clog2(SD + 1);

  logic           en;
  logic [3:0]     opc;
  logic           x;
  logic [AW-1:0]  dir;
  logic [AW-1:0]  pc;
  logic [SPW-1:0] sp;
  logic           halted;
  logic           stk_ovf;
  logic           stk_unf;

  modport master (
    output en, opc, x, dir,
    input  pc, sp, halted, stk_ovf, stk_unf
  );

  modport slave (
    input  en, opc, x, dir,
    output pc, sp, halted, stk_ovf, stk_unf
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer - parametrised program-counter sequencer with a hardware
// return stack, PC-relative branches, stall/halt control and sticky
// stack-fault flags.
//   ck   : clock, all state updates on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : pc_sequencer_if slave modport (en/opc/x/dir in; pc/sp/halted/
//          stk_ovf/stk_unf out, all outputs driven straight from registers)
// Parameters: AW address width (2..16), SD return-stack depth (1..16),
// RST_ADDR pc value loaded on reset.
module pc_sequencer #(
  parameter int            AW       = 4,
  parameter int            SD       = 4,
  parameter logic [AW-1:0] RST_ADDR = {AW{1'b0}}
) (
  input  logic             ck,
  input  logic             rst,
  pc_sequencer_if.slave    bus
);

  localparam int SPW = $clog2(SD + 1);
  localparam int IW  = (SD > 1) ? $clog2(SD) : 1;

  localparam logic [SPW-1:0] SP_FULL  = SPW'(SD);
  localparam logic [SPW-1:0] SP_EMPTY = {SPW{1'b0}};

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_JMP  = 4'b0001;
  localparam logic [3:0] OP_JC   = 4'b0010;
  localparam logic [3:0] OP_JNC  = 4'b0011;
  localparam logic [3:0] OP_CALL = 4'b0100;
  localparam logic [3:0] OP_RET  = 4'b0101;
  localparam logic [3:0] OP_BR   = 4'b0110;
  localparam logic [3:0] OP_BRC  = 4'b0111;
  localparam logic [3:0] OP_HALT = 4'b1000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t         state_r, state_s;
  logic [AW-1:0]  pc_r, pc_s;
  logic [SPW-1:0] sp_r, sp_s;
  logic           ovf_r, ovf_s;
  logic           unf_r, unf_s;
  logic           push_s;
  logic [AW-1:0]  inc_s, rel_s, top_s;
  logic [IW-1:0]  wr_idx_s, rd_idx_s;
  logic [AW-1:0]  stk_r [SD];

  assign inc_s    = pc_r + AW'(1);
  // dir has the same width as pc, so a plain AW-bit add is exactly
  // pc + sext(dir) modulo 2^AW.
  assign rel_s    = pc_r + bus.dir;
  // Pushes only happen while sp < SD, so the truncated index is always in range.
  assign wr_idx_s = IW'(sp_r);
  assign rd_idx_s = IW'(sp_r - SPW'(1));
  assign top_s    = stk_r[rd_idx_s];

  // Next-state, next-pc and stack-control decode.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    sp_s    = sp_r;
    ovf_s   = ovf_r;
    unf_s   = unf_r;
    push_s  = 1'b0;
    if (bus.en && (state_r == ST_RUN)) begin
      case (bus.opc)
        OP_NOP:  pc_s = inc_s;
        OP_JMP:  pc_s = bus.dir;
        OP_JC:   pc_s = bus.x ? bus.dir : inc_s;
        OP_JNC:  pc_s = bus.x ? inc_s : bus.dir;
        OP_CALL: begin
          if (sp_r != SP_FULL) begin
            push_s = 1'b1;
            sp_s   = sp_r + SPW'(1);
            pc_s   = bus.dir;
          end else begin
            pc_s   = inc_s;
            ovf_s  = 1'b1;
          end
        end
        OP_RET: begin
          if (sp_r != SP_EMPTY) begin
            sp_s  = sp_r - SPW'(1);
            pc_s  = top_s;
          end else begin
            pc_s  = inc_s;
            unf_s = 1'b1;
          end
        end
        OP_BR:   pc_s = rel_s;
        OP_BRC:  pc_s = bus.x ? rel_s : inc_s;
        // pc keeps the HALT instruction's own address.
        OP_HALT: state_s = ST_HALT;
        default: pc_s = inc_s;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, pc, stack pointer and sticky flag registers.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
      pc_r    <= RST_ADDR;
      sp_r    <= SP_EMPTY;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      sp_r    <= sp_s;
      ovf_r   <= ovf_s;
      unf_r   <= unf_s;
    end
  end

  // Return-stack storage; only the entry at sp is written on a push.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SD; i++) begin
        stk_r[i] <= {AW{1'b0}};
      end
    end else if (push_s) begin
      stk_r[wr_idx_s] <= inc_s;
    end else begin
      stk_r[wr_idx_s] <= stk_r[wr_idx_s];
    end
  end

  assign bus.pc      = pc_r;
  assign bus.sp      = sp_r;
  assign bus.halted  = (state_r == ST_HALT);
  assign bus.stk_ovf = ovf_r;
  assign bus.stk_unf = unf_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer - scoreboard bench for pc_sequencer (AW=4, SD=2,
// RST_ADDR=0xE). A driver issues one operation per cycle and pushes the
// reference model's expected outputs; a monitor pops and compares them
// after every rising edge.
module tb_pc_sequencer;
  localparam int AW  = 4;
  localparam int SDP = 2;
  localparam int M   = 1 << AW;
  localparam int RA  = 14;

  typedef struct {
    int pc;
    int sp;
    bit hlt;
    bit ovf;
    bit unf;
  } exp_t;

  logic ck;
  logic rst;
  int   total;
  int   bad;
  exp_t exp_q[$];
  exp_t mon_e;

  // reference model state
  int   m_pc;
  int   m_stk[$];
  bit   m_hlt;
  bit   m_ovf;
  bit   m_unf;

  pc_sequencer_if #(.AW(AW), .SD(SDP)) bus ();

  pc_sequencer #(.AW(AW), .SD(SDP), .RST_ADDR(4'hE)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = RA;
    m_stk.delete();
    m_hlt = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input bit en, input int opc, input bit x, input int dir);
    int inc, sdir, rel;
    inc  = (m_pc + 1) % M;
    sdir = (dir >= M / 2) ? dir - M : dir;
    rel  = (((m_pc + sdir) % M) + M) % M;
    if (en && !m_hlt) begin
      case (opc)
        1: m_pc = dir;
        2: m_pc = x ? dir : inc;
        3: m_pc = x ? inc : dir;
        4: begin
          if (m_stk.size() < SDP) begin
            m_stk.push_back(inc);
            m_pc = dir;
          end else begin
            m_pc  = inc;
            m_ovf = 1'b1;
          end
        end
        5: begin
          if (m_stk.size() > 0) begin
            m_pc = m_stk.pop_back();
          end else begin
            m_pc  = inc;
            m_unf = 1'b1;
          end
        end
        6: m_pc = rel;
        7: m_pc = x ? rel : inc;
        8: m_hlt = 1'b1;
        default: m_pc = inc;
      endcase
    end
  endtask

  task automatic do_op(input bit en, input logic [3:0] opc, input bit x, input logic [3:0] dir);
    exp_t e;
    @(negedge ck);
    bus.en  = en;
    bus.opc = opc;
    bus.x   = x;
    bus.dir = dir;
    model_step(en, int'(opc), x, int'(dir));
    e.pc  = m_pc;
    e.sp  = m_stk.size();
    e.hlt = m_hlt;
    e.ovf = m_ovf;
    e.unf = m_unf;
    exp_q.push_back(e);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"}, int'(bus.pc), RA);
    chk({tag, "_sp"}, int'(bus.sp), 0);
    chk({tag, "_halted"}, int'(bus.halted), 0);
    chk({tag, "_ovf"}, int'(bus.stk_ovf), 0);
    chk({tag, "_unf"}, int'(bus.stk_unf), 0);
  endtask

  // Reset asserted between edges while a CALL is presented; release with
  // the sequencer stalled so no unchecked edge executes.
  task automatic async_reset(input string tag);
    @(negedge ck);
    bus.en  = 1'b1;
    bus.opc = 4'h4;
    bus.x   = 1'b0;
    bus.dir = 4'h5;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state(tag);
    model_reset();
    @(negedge ck);
    chk_reset_state({tag, "_held"});
    bus.en = 1'b0;
    rst    = 1'b0;
  endtask

  // Monitor: compare DUT outputs against the oldest expectation after each edge.
  always @(posedge ck) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("pc", int'(bus.pc), mon_e.pc);
      chk("sp", int'(bus.sp), mon_e.sp);
      chk("halted", int'(bus.halted), int'(mon_e.hlt));
      chk("stk_ovf", int'(bus.stk_ovf), int'(mon_e.ovf));
      chk("stk_unf", int'(bus.stk_unf), int'(mon_e.unf));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r_opc;
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.opc = 4'h0;
    bus.x   = 1'b0;
    bus.dir = 4'h0;
    model_reset();
    #3;
    chk_reset_state("reset");
    @(negedge ck);
    rst = 1'b0;

    // NOP wrap 0xE -> 0xF -> 0x0 -> 0x1
    repeat (3) do_op(1'b1, 4'h0, 1'b0, 4'h0);
    // conditionals
    do_op(1'b1, 4'h0, 1'b0, 4'h0);
    do_op(1'b1, 4'h2, 1'b0, 4'h5);
    do_op(1'b1, 4'h1, 1'b0, 4'h2);
    do_op(1'b1, 4'h2, 1'b1, 4'h5);
    do_op(1'b1, 4'h1, 1'b0, 4'h2);
    do_op(1'b1, 4'h3, 1'b1, 4'h5);
    do_op(1'b1, 4'h1, 1'b0, 4'h2);
    do_op(1'b1, 4'h3, 1'b0, 4'h5);
    do_op(1'b1, 4'h1, 1'b0, 4'h2);
    do_op(1'b1, 4'h7, 1'b0, 4'hD);
    do_op(1'b1, 4'h7, 1'b1, 4'hD);
    // relative branch with wrap both ways
    do_op(1'b1, 4'h1, 1'b0, 4'h2);
    do_op(1'b1, 4'h6, 1'b0, 4'hD);
    do_op(1'b1, 4'h6, 1'b0, 4'h3);
    // nested calls, overflow, returns, underflow
    do_op(1'b1, 4'h1, 1'b0, 4'h1);
    do_op(1'b1, 4'h4, 1'b0, 4'h8);
    do_op(1'b1, 4'h4, 1'b0, 4'hC);
    do_op(1'b1, 4'h4, 1'b0, 4'h4);
    do_op(1'b1, 4'h5, 1'b0, 4'h0);
    do_op(1'b1, 4'h5, 1'b0, 4'h0);
    do_op(1'b1, 4'h5, 1'b0, 4'h0);
    // back-to-back CALL/RET, then stall with JMP presented
    do_op(1'b1, 4'h4, 1'b0, 4'hA);
    do_op(1'b1, 4'h5, 1'b0, 4'h0);
    do_op(1'b1, 4'h4, 1'b0, 4'h9);
    repeat (3) do_op(1'b0, 4'h1, 1'b1, 4'h7);
    // async reset mid-CALL sequence; stack must come back empty
    async_reset("arst1");
    do_op(1'b1, 4'h5, 1'b0, 4'h0);

    // randomized operations (HALT kept for the final phase)
    for (int i = 0; i < 400; i++) begin
      r_opc = 4'($urandom_range(0, 15));
      if (r_opc == 4'h8) r_opc = 4'h5;
      do_op(($urandom_range(0, 9) != 0), r_opc, 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)));
    end

    // halt at pc=6, then anything is ignored
    do_op(1'b1, 4'h1, 1'b0, 4'h6);
    do_op(1'b1, 4'h8, 1'b0, 4'h0);
    for (int i = 0; i < 12; i++) begin
      do_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    async_reset("arst2");
    do_op(1'b1, 4'h0, 1'b0, 4'h0);

    @(negedge ck);
    bus.en = 1'b0;
    repeat (2) @(posedge ck);
    #2;
    chk("drain_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the Mica CPU family. It supersedes the fixed 4-bit counter with a configurable address width, a hardware return stack for CALL/RET, PC-relative branches, stall and halt control, and sticky stack-fault flags. It sits between the instruction decoder, which supplies the opcode, condition flag and target field, and program memory, which is addressed by `pc`.

## Interface
Parameters:
- `AW`, 4, address width (pc, dir, stack entries); legal range 2..16
- `SD`, 4, return-stack depth in entries; legal range 1..16
- `RST_ADDR`, 0, pc value loaded on reset (AW bits)

Ports:
- `ck`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  advance enable; 0 = stall, all state held
- `opc`  in  4  sequencing opcode from decoder
- `x`  in  1  condition flag for conditional opcodes
- `dir`  in  AW  absolute target, or two's-complement offset for relative branches
- `pc`  out  AW  current program address, registered
- `sp`  out  clog2(SD+1)  number of valid stack entries, registered
- `halted`  out  1  set by HALT; sticky until reset
- `stk_ovf`  out  1  sticky; CALL attempted with stack full
- `stk_unf`  out  1  sticky; RET attempted with stack empty

## Operation
- Next-pc rules, evaluated only when `en`=1 and `halted`=0. Here inc = pc+1 mod 2^AW.
  - 0000 NOP: pc <= inc
  - 0001 JMP: pc <= dir
  - 0010 JC: x=1 -> pc <= dir; x=0 -> pc <= inc
  - 0011 JNC: x=0 -> pc <= dir; x=1 -> pc <= inc
  - 0100 CALL: if sp<SD, push inc, sp+1, pc <= dir. If full: no push, pc <= inc, stk_ovf <= 1.
  - 0101 RET: if sp>0, pc <= top, sp-1. If empty: pc <= inc, stk_unf <= 1.
  - 0110 BR: pc <= pc + sext(dir), mod 2^AW
  - 0111 BRC: x=1 -> pc <= pc + sext(dir); x=0 -> pc <= inc
  - 1000 HALT: pc held, halted <= 1
  - 1001..1111: reserved, behave as NOP
- Stack behaviour:
  - The stack is LIFO. Entries are stored in a register array indexed by sp.
  - Entries above sp are don't-care and are never observable.
  - A faulting CALL does not overwrite the top entry.
- Flags:
  - stk_ovf and stk_unf, once set, stay set until `rst`.
  - Subsequent operations continue normally while a flag is set.
- Halt:
  - While halted=1, pc, sp and all flags are frozen regardless of `en`, `opc` and `x`.
  - Only `rst` leaves the halted state.
- Stall: `en`=0 freezes pc, sp, stack contents and flags. `opc` is ignored that cycle.
- Arithmetic: all pc arithmetic is AW bits with silent wrap-around (all-ones+1 = 0; 0 + (-1) = all-ones). No carry is reported.

## Timing
- Reset:
  - `rst` high asynchronously forces pc=RST_ADDR, sp=0, halted=0, stk_ovf=0, stk_unf=0, independent of `ck`.
  - The first opcode is evaluated on the first rising edge with `rst` low.
  - Reset asserted mid-CALL or mid-RET discards the stack operation entirely.
- Latency: inputs are sampled on the rising edge of `ck`. The new pc, sp and flags are visible immediately after that edge, one cycle of latency.
- Combinational paths: none from inputs to outputs; all outputs come straight from registers.
- Timing of flag and halt updates:
  - A fault flag rises on the same edge that applies the fallback pc.
  - halted rises on the HALT edge, and pc keeps the HALT instruction's address.
- Back-to-back operations: CALL then RET on consecutive cycles returns to the CALL address+1 with no bubble.

## Test plan
- Reset/NOP wrap: AW=4, RST_ADDR=0xE, 3 NOPs -> pc sequence 0xE, 0xF, 0x0, 0x1.
- Conditionals:
  - JC dir=5 with x=0 at pc=2 -> pc=3.
  - JC dir=5 with x=1 -> pc=5.
  - JNC and BRC mirror-checked.
- Relative branch: pc=0x2, BR dir=0xD (-3) -> pc=0xF; BR dir=0x3 -> pc=0x2.
- Nested calls and overflow:
  - SD=2, at pc=1 CALL 8 -> pc=8, sp=1.
  - CALL 0xC -> pc=0xC, sp=2.
  - CALL 4 -> pc=0xD, stk_ovf=1, sp=2.
  - RET, RET -> pc=9 then pc=2, sp=0.
  - RET -> pc=3, stk_unf=1.
- Stall/halt:
  - en=0 for 3 cycles with opc=JMP -> pc, sp unchanged.
  - HALT at pc=6 -> halted=1, pc stays 6 under any opc.
- Async reset mid-operation:
  - Assert rst between edges during a CALL sequence -> outputs go to reset values immediately.
  - After release, the stack is empty (RET raises stk_unf).
